// File: rtl/debouncer_bank_pkg.sv
// Shared types and elaboration helpers for the push-button debouncer bank.
package debouncer_bank_pkg;

    // Auto-repeat phase: which limit the repeat counter is running towards.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_DELAY = 2'd1,
        PH_RATE  = 2'd2
    } rep_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int count_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/debouncer_bank_channel.sv
// One debounced key: tick-qualified stability filter, edge pulses and auto-repeat.
module debounce_channel
    import debouncer_bank_pkg::*;
#(
    parameter int STABLE       = 8,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync_in,
    output logic state,
    output logic down,
    output logic up,
    output logic press
);

    localparam int CW = count_width(STABLE);
    localparam int RW = count_width(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic            state_reg, state_next;
    logic            down_reg, down_next;
    logic            up_reg, up_next;
    logic            press_reg, press_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   rcnt_reg, rcnt_next;
    rep_phase_t      phase_reg, phase_next;
    logic [RW-1:0]   rep_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= 1'b0;
            down_reg  <= 1'b0;
            up_reg    <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
            rcnt_reg  <= '0;
            phase_reg <= PH_IDLE;
        end else begin
            state_reg <= state_next;
            down_reg  <= down_next;
            up_reg    <= up_next;
            press_reg <= press_next;
            cnt_reg   <= cnt_next;
            rcnt_reg  <= rcnt_next;
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        down_next  = 1'b0;
        up_next    = 1'b0;
        press_next = 1'b0;
        rcnt_next  = rcnt_reg;
        phase_next = phase_reg;
        rep_last   = (phase_reg == PH_RATE) ? RATE_LAST : DELAY_LAST;

        // A single agreeing sample throws away any partial qualification.
        if (sync_in == state_reg) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt_reg == CNT_LAST) begin
                state_next = ~state_reg;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        down_next = state_next & ~state_reg;
        up_next   = ~state_next & state_reg;

        if (!REPEAT_EN) begin
            press_next = down_next;
            rcnt_next  = '0;
            phase_next = PH_IDLE;
        end else if (!state_next) begin
            // Covers the release cycle too, so a repeat due on that tick is dropped.
            rcnt_next  = '0;
            phase_next = PH_IDLE;
        end else if (down_next) begin
            press_next = 1'b1;
            rcnt_next  = '0;
            phase_next = PH_DELAY;
        end else if (tick) begin
            if (rcnt_reg == rep_last) begin
                press_next = 1'b1;
                rcnt_next  = '0;
                phase_next = PH_RATE;
            end else begin
                rcnt_next = rcnt_reg + 1'b1;
            end
        end
    end

    assign state = state_reg;
    assign down  = down_reg;
    assign up    = up_reg;
    assign press = press_reg;

endmodule

// File: rtl/debouncer_bank.sv
// N-channel push-button conditioner: polarity fix, 2-FF synchroniser, shared tick
// prescaler and one debounce_channel per key.
module debouncer_bank
    import debouncer_bank_pkg::*;
#(
    parameter int N            = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int PRESCALE     = 16,
    parameter int STABLE       = 8,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] state,
    output logic [N-1:0] down,
    output logic [N-1:0] up,
    output logic [N-1:0] press
);

    localparam int PW = count_width(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_reg, pre_next;
    logic          tick;
    logic [N-1:0]  s0_reg, s1_reg;

    // Free-running so tick phase never depends on button activity.
    always_comb begin
        tick     = (pre_reg == PRE_LAST);
        pre_next = tick ? '0 : pre_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
            s0_reg  <= '0;
            s1_reg  <= '0;
        end else begin
            pre_reg <= pre_next;
            s0_reg  <= pb_in ^ {N{ACTIVE_LOW}};
            s1_reg  <= s0_reg;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        debounce_channel #(
            .STABLE       (STABLE),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .sync_in (s1_reg[gi]),
            .state   (state[gi]),
            .down    (down[gi]),
            .up      (up[gi]),
            .press   (press[gi])
        );
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank: scheduled output events in a queue, checked every cycle.
module tb_debouncer_bank;

    logic       clk;
    logic       rst, rst4;
    logic [1:0] pb_in, pb4;
    logic [1:0] state, down, up, press;
    logic [1:0] state4, down4, up4, press4;

    debouncer_bank #(
        .N(2), .ACTIVE_LOW(1'b1), .PRESCALE(1), .STABLE(4),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(3)
    ) u_dut (
        .clk(clk), .rst(rst), .pb_in(pb_in),
        .state(state), .down(down), .up(up), .press(press)
    );

    debouncer_bank #(
        .N(2), .ACTIVE_LOW(1'b1), .PRESCALE(4), .STABLE(4),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(3)
    ) u_dut4 (
        .clk(clk), .rst(rst4), .pb_in(pb4),
        .state(state4), .down(down4), .up(up4), .press(press4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [1:0] dn;
        logic [1:0] upv;
        logic [1:0] pr;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_state = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [1:0] s, input logic [1:0] d,
                            input logic [1:0] u, input logic [1:0] p);
        exp_t e;
        e.cyc = c; e.st = s; e.dn = d; e.upv = u; e.pr = p;
        sb.push_back(e);
    endtask

    // One clock; compare the main DUT against the scheduled event or the idle level.
    task automatic tick1();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("event", {24'd0, state, down, up, press}, {24'd0, e.st, e.dn, e.upv, e.pr});
            exp_state = e.st;
        end else begin
            check("idle", {24'd0, state, down, up, press}, {24'd0, exp_state, 6'b0});
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick1();
    endtask

    initial begin
        int t, d, lat;
        bit got, sawup;

        // Reset with both keys held; nothing may leave the DUT while rst is high.
        rst = 1'b1; pb_in = 2'b00;
        rst4 = 1'b1; pb4 = 2'b10;
        repeat (3) tick1();
        rst = 1'b0;
        t = cyc;
        push_exp(t + 6, 2'b11, 2'b11, 2'b00, 2'b11);
        run_until(t + 6);
        pb_in = 2'b11;
        t = cyc;
        push_exp(t + 6, 2'b00, 2'b00, 2'b11, 2'b00);
        run_until(t + 8);

        // Clean press and release of channel 0.
        pb_in = 2'b10;
        t = cyc;
        push_exp(t + 6, 2'b01, 2'b01, 2'b00, 2'b01);
        run_until(t + 6);
        pb_in = 2'b11;
        t = cyc;
        push_exp(t + 6, 2'b00, 2'b00, 2'b01, 2'b00);
        run_until(t + 8);

        // Bounce every 3 clks never qualifies.
        for (int i = 0; i < 10; i++) begin
            pb_in[0] = ~pb_in[0];
            repeat (3) tick1();
        end

        // Final edge then long hold: auto-repeat, release landing on a repeat tick.
        pb_in[0] = 1'b0;
        t = cyc;
        d = t + 6;
        push_exp(d, 2'b01, 2'b01, 2'b00, 2'b01);
        for (int k = 0; k <= 10; k++) push_exp(d + 8 + 3 * k, 2'b01, 2'b00, 2'b00, 2'b01);
        run_until(d + 35);
        pb_in = 2'b11;
        push_exp(d + 41, 2'b00, 2'b00, 2'b01, 2'b00);
        run_until(d + 53);

        // Simultaneous press on ch0 and release on ch1.
        pb_in = 2'b01;
        t = cyc;
        push_exp(t + 6, 2'b10, 2'b10, 2'b00, 2'b10);
        run_until(t + 6);
        pb_in = 2'b10;
        t = cyc;
        d = t + 6;
        push_exp(d, 2'b01, 2'b01, 2'b10, 2'b01);
        push_exp(d + 8, 2'b01, 2'b00, 2'b00, 2'b01);
        push_exp(d + 11, 2'b01, 2'b00, 2'b00, 2'b01);
        run_until(d + 12);

        // One-clock reset during auto-repeat, key still held.
        rst = 1'b1;
        push_exp(d + 13, 2'b00, 2'b00, 2'b00, 2'b00);
        tick1();
        rst = 1'b0;
        push_exp(d + 19, 2'b01, 2'b01, 2'b00, 2'b01);
        run_until(d + 19);
        pb_in = 2'b11;
        push_exp(d + 25, 2'b00, 2'b00, 2'b01, 2'b00);
        run_until(d + 28);

        // PRESCALE=4 instance: qualify, reset mid-hold, measure re-qualification.
        rst4 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick1();
            got = state4[0];
        end
        check("p4_first_down", {31'd0, got}, 32'd1);
        rst4 = 1'b1;
        tick1();
        check("p4_reset_out", {24'd0, state4, down4, up4, press4}, 32'd0);
        rst4 = 1'b0;
        lat = 0;
        sawup = 1'b0;
        while (!down4[0] && lat < 40) begin
            tick1();
            lat++;
            if (up4 != 2'b00) sawup = 1'b1;
        end
        check("p4_latency_window", {31'd0, (lat >= 15 && lat <= 18)}, 32'd1);
        check("p4_no_up", {31'd0, sawup}, 32'd0);
        check("p4_down_state", {28'd0, state4, down4}, {28'd0, 2'b01, 2'b01});
        $display("p4 requalify latency=%0d clks", lat);

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
